// File: rtl/mdu_hilo_pkg.sv
// Shared ALU control codes for the multiply/divide unit, plus small decode helpers.
package mdu_hilo_pkg;

  localparam logic [4:0] MULT_CONTROL  = 5'b01010;
  localparam logic [4:0] MULTU_CONTROL = 5'b01011;
  localparam logic [4:0] DIV_CONTROL   = 5'b01100;
  localparam logic [4:0] DIVU_CONTROL  = 5'b01101;

  function automatic logic is_md_code(input logic [4:0] code);
    return (code == MULT_CONTROL) || (code == MULTU_CONTROL) ||
           (code == DIV_CONTROL)  || (code == DIVU_CONTROL);
  endfunction

  function automatic logic is_div_code(input logic [4:0] code);
    return (code == DIV_CONTROL) || (code == DIVU_CONTROL);
  endfunction

  function automatic logic is_signed_code(input logic [4:0] code);
    return (code == MULT_CONTROL) || (code == DIV_CONTROL);
  endfunction

endpackage

// File: rtl/mdu_hilo_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per step.
module mdu_hilo_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] trial;

  // When the trial subtract fits, the difference is below the divisor, so the
  // WIDTH-bit wrapped subtract is exact.
  always_comb begin
    shifted = {rem_q, quot_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvsr_q});
    trial   = shifted[WIDTH-1:0] - dvsr_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else if (load) begin
      quot_q <= dividend;
      rem_q  <= '0;
      dvsr_q <= divisor;
    end else if (step) begin
      rem_q  <= fits ? trial : shifted[WIDTH-1:0];
      quot_q <= {quot_q[WIDTH-2:0], fits};
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers; stalls EX while an operation runs.
//
//   state  | meaning
//   IDLE   | waiting for a mult/div in EX; MTHI/MTLO only
//   RUN    | one shift-add or restoring-divide step per cycle, stall held
//   DONE   | result written to HI/LO at this edge, instruction leaves EX
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int FAST_MUL = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [4:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   op_a_q, op_b_q;
  logic               sgn_q, is_div_q;
  logic [2*WIDTH-1:0] mul_acc_q;

  logic               md_op, accept;
  logic               sgn_in;
  logic [WIDTH-1:0]   mag_src_a, mag_src_b;
  logic               neg_a, neg_q;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod_mag, prod;
  logic [WIDTH-1:0]   quot, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign md_op     = start & is_md_code(alu_control);
  assign accept    = (state_q == S_IDLE) & md_op & ~flush;
  assign sgn_in    = is_signed_code(alu_control);
  assign mag_src_a = (sgn_in & src_a[WIDTH-1]) ? -src_a : src_a;
  assign mag_src_b = (sgn_in & src_b[WIDTH-1]) ? -src_b : src_b;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          stall   = 1'b1;
          state_d = ((FAST_MUL != 0) && !is_div_code(alu_control)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        stall = 1'b1;
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush cancels from any state; in DONE it also suppresses the write.
    if (flush) begin
      state_d = S_IDLE;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  assign busy = (state_q != S_IDLE);

  always_comb begin
    neg_a    = sgn_q & op_a_q[WIDTH-1];
    neg_q    = sgn_q & (op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1]);
    mag_a    = neg_a ? -op_a_q : op_a_q;
    mag_b    = (sgn_q & op_b_q[WIDTH-1]) ? -op_b_q : op_b_q;
    mul_sum  = {1'b0, mul_acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
    mul_next = mul_acc_q[0] ? {mul_sum, mul_acc_q[WIDTH-1:1]}
                            : {1'b0, mul_acc_q[2*WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      sgn_q     <= 1'b0;
      is_div_q  <= 1'b0;
      mul_acc_q <= '0;
    end else if (accept) begin
      cnt_q     <= CW'(WIDTH);
      op_a_q    <= src_a;
      op_b_q    <= src_b;
      sgn_q     <= sgn_in;
      is_div_q  <= is_div_code(alu_control);
      mul_acc_q <= {{WIDTH{1'b0}}, mag_src_b};
    end else if (state_q == S_RUN) begin
      cnt_q <= cnt_q - CW'(1);
      if (!is_div_q) mul_acc_q <= mul_next;
    end
  end

  mdu_hilo_div_core #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .load     (accept),
    .step     ((state_q == S_RUN) & is_div_q),
    .dividend (mag_src_a),
    .divisor  (mag_src_b),
    .quot     (quot),
    .rem      (rem)
  );

  assign prod_mag = (FAST_MUL != 0) ? ({{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b})
                                    : mul_acc_q;
  assign prod     = neg_q ? -prod_mag : prod_mag;

  // Divide by zero bypasses the sign fix-up: LO all ones, HI the raw dividend.
  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div_q) begin
      if (op_b_q == '0) begin
        res_hi = op_a_q;
        res_lo = '1;
      end else begin
        res_hi = neg_a ? -rem : rem;
        res_lo = neg_q ? -quot : quot;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      hi <= res_hi;
      lo <= res_lo;
    end else begin
      if (hi_we) hi <= hilo_wdata;
      if (lo_we) lo <= hilo_wdata;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: one fast-multiply and one iterative-multiply instance.
module tb_mdu_hilo;
  import mdu_hilo_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start, use_s;
  logic [4:0]  ctrl;
  logic [31:0] src_a, src_b, hilo_wdata;
  logic        flush, hi_we, lo_we;
  logic        stall_f, busy_f, done_f, stall_s, busy_s, done_s;
  logic [31:0] hi_f, lo_f, hi_s, lo_s;
  logic        stall_x, busy_x, done_x;
  logic [31:0] hi_x, lo_x;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  mdu_hilo #(.WIDTH(32), .FAST_MUL(1)) dut_f (
    .clk(clk), .resetn(resetn), .start(start & ~use_s), .alu_control(ctrl),
    .src_a(src_a), .src_b(src_b), .flush(flush), .hi_we(hi_we & ~use_s),
    .lo_we(lo_we & ~use_s), .hilo_wdata(hilo_wdata), .stall(stall_f),
    .busy(busy_f), .done(done_f), .hi(hi_f), .lo(lo_f));

  mdu_hilo #(.WIDTH(32), .FAST_MUL(0)) dut_s (
    .clk(clk), .resetn(resetn), .start(start & use_s), .alu_control(ctrl),
    .src_a(src_a), .src_b(src_b), .flush(flush), .hi_we(hi_we & use_s),
    .lo_we(lo_we & use_s), .hilo_wdata(hilo_wdata), .stall(stall_s),
    .busy(busy_s), .done(done_s), .hi(hi_s), .lo(lo_s));

  assign stall_x = use_s ? stall_s : stall_f;
  assign busy_x  = use_s ? busy_s  : busy_f;
  assign done_x  = use_s ? done_s  : done_f;
  assign hi_x    = use_s ? hi_s    : hi_f;
  assign lo_x    = use_s ? lo_s    : lo_f;

  typedef struct {
    logic        s;
    logic [4:0]  c;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Issue one op and hold start until the DONE cycle; latency = stall cycles seen.
  task automatic run_op(input logic s, input logic [4:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi_e,
                        input logic [31:0] lo_e, input int lat_e, input string nm);
    int lat;
    use_s = s; ctrl = c; src_a = a; src_b = b; start = 1'b1; lat = 0;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (!stall_x) break;
      lat++;
      @(negedge clk);
    end
    chk({nm, " latency"}, lat, lat_e);
    chk({nm, " done"}, {31'b0, done_x}, 32'd1);
    start = 1'b0;
    @(negedge clk); #1;
    chk({nm, " hi"}, hi_x, hi_e);
    chk({nm, " lo"}, lo_x, lo_e);
    chk({nm, " done low after"}, {31'b0, done_x}, 32'd0);
    chk({nm, " busy low after"}, {31'b0, busy_x}, 32'd0);
  endtask

  initial begin
    tv[0]  = '{1'b0, MULT_CONTROL,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1};
    tv[1]  = '{1'b0, MULTU_CONTROL, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 1};
    tv[2]  = '{1'b1, MULTU_CONTROL, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 33};
    tv[3]  = '{1'b1, MULT_CONTROL,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    tv[4]  = '{1'b0, DIV_CONTROL,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    tv[5]  = '{1'b0, DIVU_CONTROL,  32'h7, 32'h2, 32'h1, 32'h3, 33};
    tv[6]  = '{1'b0, DIVU_CONTROL,  32'h7, 32'h0, 32'h7, 32'hFFFFFFFF, 33};
    tv[7]  = '{1'b1, DIV_CONTROL,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33};
    tv[8]  = '{1'b0, MULT_CONTROL,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1};
    tv[9]  = '{1'b1, DIV_CONTROL,   32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 33};
    tv[10] = '{1'b0, DIV_CONTROL,   32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 33};
    tv[11] = '{1'b1, MULT_CONTROL,  32'h12345678, 32'h10, 32'h1, 32'h23456780, 33};
    tv[12] = '{1'b1, DIVU_CONTROL,  32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 33};

    resetn = 1'b0; start = 1'b0; use_s = 1'b0; ctrl = '0; src_a = '0; src_b = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; hilo_wdata = '0;
    #1;
    chk("reset hi_f", hi_f, 32'h0);
    chk("reset lo_f", lo_f, 32'h0);
    chk("reset hi_s", hi_s, 32'h0);
    chk("reset busy/done/stall", {29'b0, busy_f | busy_s, done_f | done_s, stall_f | stall_s}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 13; i++)
      run_op(tv[i].s, tv[i].c, tv[i].a, tv[i].b, tv[i].hi, tv[i].lo, tv[i].lat,
             $sformatf("vec%0d", i));

    // Non-multiply codes never engage the unit.
    use_s = 1'b0; ctrl = 5'b00010; start = 1'b1;
    #1 chk("non-md stall", {31'b0, stall_f}, 32'd0);
    @(negedge clk); #1;
    chk("non-md busy", {31'b0, busy_f}, 32'd0);
    start = 1'b0;

    run_op(1'b0, DIVU_CONTROL, 32'h7, 32'h2, 32'h1, 32'h3, 33, "pre-flush");

    // Flush in IDLE with a valid op: not accepted.
    ctrl = DIV_CONTROL; src_a = 32'd100; src_b = 32'd7; start = 1'b1; flush = 1'b1;
    #1 chk("flush idle stall", {31'b0, stall_f}, 32'd0);
    @(negedge clk); #1;
    chk("flush idle busy", {31'b0, busy_f}, 32'd0);
    flush = 1'b0; start = 1'b0;

    // Flush in RUN cycle 10.
    start = 1'b1;
    repeat (10) @(negedge clk);
    #1 chk("run before flush busy", {31'b0, busy_f}, 32'd1);
    flush = 1'b1;
    #1 chk("flush run done", {31'b0, done_f}, 32'd0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    chk("flush run busy", {31'b0, busy_f}, 32'd0);
    chk("flush run hi", hi_f, 32'h1);
    chk("flush run lo", lo_f, 32'h3);
    repeat (3) @(negedge clk);
    #1 chk("flush run no late done", {31'b0, done_f | busy_f}, 32'd0);

    run_op(1'b0, DIV_CONTROL, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, "after-flush");

    // Flush in DONE suppresses the pulse and the write.
    ctrl = MULTU_CONTROL; src_a = 32'hFFFFFFFF; src_b = 32'h2; start = 1'b1;
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flush done pulse", {31'b0, done_f}, 32'd0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    chk("flush done hi", hi_f, 32'hFFFFFFFF);
    chk("flush done lo", lo_f, 32'hFFFFFFFD);

    // MTHI / MTLO.
    hilo_wdata = 32'h55555555; hi_we = 1'b1;
    @(negedge clk);
    hi_we = 1'b0; hilo_wdata = 32'hAAAAAAAA; lo_we = 1'b1;
    @(negedge clk);
    lo_we = 1'b0;
    #1;
    chk("mthi", hi_f, 32'h55555555);
    chk("mtlo", lo_f, 32'hAAAAAAAA);

    // MT in the DONE cycle loses to the result.
    ctrl = MULTU_CONTROL; src_a = 32'hFFFFFFFF; src_b = 32'h2; start = 1'b1;
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; hilo_wdata = 32'hDEADBEEF;
    #1 chk("mt+done pulse", {31'b0, done_f}, 32'd1);
    start = 1'b0;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    #1;
    chk("mt+done hi", hi_f, 32'h1);
    chk("mt+done lo", lo_f, 32'hFFFFFFFE);

    // Reset mid-divide clears everything immediately.
    use_s = 1'b1; ctrl = DIV_CONTROL; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    repeat (5) @(negedge clk);
    #1 chk("pre-reset busy", {31'b0, busy_s}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("async reset hi_s", hi_s, 32'h0);
    chk("async reset lo_s", lo_s, 32'h0);
    chk("async reset hi_f", hi_f, 32'h0);
    chk("async reset busy", {31'b0, busy_s}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk); #1;
    chk("post reset done", {31'b0, done_s}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
